// File: rtl/cordic_scheduler.sv
// Round-robin scheduler sharing one cordic_top among N_REQ requesters.
// One job in flight at a time; a response is returned per job, tagged with the requester index.
module cordic_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_angle,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [2:0]           resp_id,
  output logic [31:0]          resp_sin,
  output logic [31:0]          resp_cos,
  output logic                 resp_err,
  output logic                 cor_valid,
  output logic [31:0]          cor_angle,
  input  logic [31:0]          cor_sin,
  input  logic [31:0]          cor_cos,
  input  logic                 cor_done,
  output logic                 busy
);

  localparam int          PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;
  logic [PW-1:0] ptr_next;
  logic          win_found;
  logic [2:0]    id_reg;
  logic [15:0]   wait_cnt;
  logic [31:0]   angle_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_angle
    assign angle_arr[g] = req_angle[32*g +: 32];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PW'((32'(rr_ptr) + i) % 32'(N_REQ));
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_reg     <= '0;
      wait_cnt   <= '0;
      cor_valid  <= 1'b0;
      cor_angle  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sin   <= '0;
      resp_cos   <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            cor_angle <= angle_arr[win_idx];
            id_reg    <= 3'(win_idx);
            rr_ptr    <= ptr_next;
            cor_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cor_valid <= 1'b0;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // done takes priority over a timeout landing on the same cycle
          if (cor_done) begin
            resp_sin   <= cor_sin;
            resp_cos   <= cor_cos;
            resp_err   <= 1'b0;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt == TO_LAST) begin
            resp_sin   <= QNAN;
            resp_cos   <= QNAN;
            resp_err   <= 1'b1;
            resp_id    <= id_reg;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler: a default instance with a 40-cycle CORDIC model,
// and a TIMEOUT=16 instance whose done line is driven directly.
module tb_cordic_scheduler;

  localparam logic [31:0] SIN1  = 32'h3F576AA4;
  localparam logic [31:0] COS1  = 32'h3F0A5140;
  localparam logic [31:0] QNAN  = 32'h7FC00000;
  localparam int          DLY   = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_valid_b;
  logic [127:0] req_angle;
  logic         resp_ready, resp_ready_b;
  logic [31:0]  cor_sin_c, cor_cos_c;

  logic [3:0]   req_ready_a, req_ready_b;
  logic         resp_valid_a, resp_valid_b;
  logic [2:0]   resp_id_a, resp_id_b;
  logic [31:0]  resp_sin_a, resp_sin_b, resp_cos_a, resp_cos_b;
  logic         resp_err_a, resp_err_b;
  logic         cor_valid_a, cor_valid_b;
  logic [31:0]  cor_angle_a, cor_angle_b;
  logic         busy_a, busy_b;
  logic         cor_done_a = 1'b0;
  logic         cor_done_b;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  int cv_cnt = 0;
  int k;
  int base;

  always #5 clk = ~clk;

  cordic_scheduler #(.N_REQ(4), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready_a),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_id(resp_id_a),
    .resp_sin(resp_sin_a), .resp_cos(resp_cos_a), .resp_err(resp_err_a),
    .cor_valid(cor_valid_a), .cor_angle(cor_angle_a),
    .cor_sin(cor_sin_c), .cor_cos(cor_cos_c), .cor_done(cor_done_a),
    .busy(busy_a)
  );

  cordic_scheduler #(.N_REQ(4), .TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_angle(req_angle), .req_ready(req_ready_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_id(resp_id_b),
    .resp_sin(resp_sin_b), .resp_cos(resp_cos_b), .resp_err(resp_err_b),
    .cor_valid(cor_valid_b), .cor_angle(cor_angle_b),
    .cor_sin(cor_sin_c), .cor_cos(cor_cos_c), .cor_done(cor_done_b),
    .busy(busy_b)
  );

  // CORDIC model: done pulses DLY cycles after the valid_in cycle.
  always @(posedge clk) begin
    if (rst) begin
      mcnt       <= 0;
      cor_done_a <= 1'b0;
    end else begin
      cor_done_a <= 1'b0;
      if (cor_valid_a) mcnt <= DLY - 1;
      else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) cor_done_a <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (cor_valid_a) cv_cnt <= cv_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_valid_b = '0; req_angle = '0;
    resp_ready = 1'b0; resp_ready_b = 1'b0; cor_done_b = 1'b0;
    cor_sin_c = SIN1; cor_cos_c = COS1;
    tick(); tick();

    // Reset values
    chk("rst_req_ready", 32'(req_ready_a), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid_a), 32'h0);
    chk("rst_resp_id", 32'(resp_id_a), 32'h0);
    chk("rst_resp_err", 32'(resp_err_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_cor_valid", 32'(cor_valid_a), 32'h0);
    chk("rst_cor_angle", cor_angle_a, 32'h0);
    chk("rst_resp_sin", resp_sin_a, 32'h0);
    chk("rst_resp_cos", resp_cos_a, 32'h0);
    rst = 1'b0;

    // Single request from requester 2, done 40 cycles after valid_in
    req_angle[2*32 +: 32] = 32'h3F800000;
    req_valid = 4'b0100;
    #1;
    chk("t1_grant", 32'(req_ready_a), 32'h4);
    tick(); k = 1;
    chk("t1_cor_valid", 32'(cor_valid_a), 32'h1);
    chk("t1_cor_angle", cor_angle_a, 32'h3F800000);
    chk("t1_ready_issue", 32'(req_ready_a), 32'h0);
    chk("t1_busy", 32'(busy_a), 32'h1);
    req_valid = '0;
    tick(); k = 2;
    chk("t1_cor_valid_off", 32'(cor_valid_a), 32'h0);
    while (!resp_valid_a && k < 100) begin tick(); k++; end
    chk("t1_latency", 32'(k), 32'd42);
    chk("t1_id", 32'(resp_id_a), 32'd2);
    chk("t1_sin", resp_sin_a, SIN1);
    chk("t1_cos", resp_cos_a, COS1);
    chk("t1_err", 32'(resp_err_a), 32'h0);
    chk("t1_cv_pulses", 32'(cv_cnt), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("t1_resp_drop", 32'(resp_valid_a), 32'h0);
    chk("t1_idle_busy", 32'(busy_a), 32'h0);

    // All four requesters valid from reset: grants 0,1,2,3,0
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req_valid = 4'b1111; resp_ready = 1'b1;
    #1;
    base = cv_cnt;
    for (int j = 0; j < 5; j++) begin
      k = 0;
      while (req_ready_a == '0 && k < 100) begin tick(); k++; end
      chk($sformatf("t2_grant%0d", j), 32'(req_ready_a), 32'(1 << (j % 4)));
      tick(); k = 0;
      while (!resp_valid_a && k < 100) begin tick(); k++; end
      chk($sformatf("t2_id%0d", j), 32'(resp_id_a), 32'(j % 4));
      chk($sformatf("t2_cv%0d", j), 32'(cv_cnt), 32'(base + j + 1));
      tick();
    end
    req_valid = '0; resp_ready = 1'b0;
    #1;

    // Backpressure: response held 10 cycles (rr_ptr now 1)
    req_angle[1*32 +: 32] = 32'h40000000;
    req_valid = 4'b0010;
    #1;
    chk("t3_grant", 32'(req_ready_a), 32'h2);
    tick();
    chk("t3_cor_angle", cor_angle_a, 32'h40000000);
    req_valid = '0;
    k = 0;
    while (!resp_valid_a && k < 100) begin tick(); k++; end
    for (int j = 0; j < 10; j++) begin
      chk("t3_hold_valid", 32'(resp_valid_a), 32'h1);
      chk("t3_hold_id", 32'(resp_id_a), 32'd1);
      chk("t3_hold_sin", resp_sin_a, SIN1);
      chk("t3_hold_ready", 32'(req_ready_a), 32'h0);
      tick();
    end
    resp_ready = 1'b1; req_valid = 4'b0010;
    #1;
    chk("t3_accept_ready", 32'(req_ready_a), 32'h0);
    tick();
    chk("t3_after_valid", 32'(resp_valid_a), 32'h0);
    chk("t3_after_ready", 32'(req_ready_a), 32'h2);
    req_valid = '0; resp_ready = 1'b0;
    #1;

    // Timeout on the TIMEOUT=16 instance: response at T+18
    req_angle[0 +: 32] = 32'h3F000000;
    req_valid_b = 4'b0001;
    #1;
    chk("t4_grant", 32'(req_ready_b), 32'h1);
    tick(); k = 1;
    req_valid_b = '0;
    while (!resp_valid_b && k < 60) begin tick(); k++; end
    chk("t4_latency", 32'(k), 32'd18);
    chk("t4_err", 32'(resp_err_b), 32'h1);
    chk("t4_sin", resp_sin_b, QNAN);
    chk("t4_cos", resp_cos_b, QNAN);
    chk("t4_id", 32'(resp_id_b), 32'd0);
    resp_ready_b = 1'b1;
    tick();
    resp_ready_b = 1'b0;
    cor_done_b = 1'b1;
    tick();
    cor_done_b = 1'b0;
    chk("t4_late_done_valid", 32'(resp_valid_b), 32'h0);
    chk("t4_late_done_busy", 32'(busy_b), 32'h0);
    tick();
    chk("t4_late_done_valid2", 32'(resp_valid_b), 32'h0);

    // done and timeout on the same cycle (T+17): done wins
    req_valid_b = 4'b0010;
    #1;
    chk("t5_grant", 32'(req_ready_b), 32'h2);
    tick();
    req_valid_b = '0;
    for (int j = 2; j <= 17; j++) tick();
    chk("t5_no_early_resp", 32'(resp_valid_b), 32'h0);
    cor_done_b = 1'b1;
    tick();
    cor_done_b = 1'b0;
    chk("t5_valid", 32'(resp_valid_b), 32'h1);
    chk("t5_err", 32'(resp_err_b), 32'h0);
    chk("t5_sin", resp_sin_b, SIN1);
    chk("t5_cos", resp_cos_b, COS1);
    chk("t5_id", 32'(resp_id_b), 32'd1);
    resp_ready_b = 1'b1;
    tick();
    resp_ready_b = 1'b0;

    // Asynchronous reset during WAIT (rr_ptr is 2 before reset)
    req_valid = 4'b1111;
    #1;
    chk("t6_grant", 32'(req_ready_a), 32'h4);
    tick(); tick(); tick(); tick();
    chk("t6_busy_pre", 32'(busy_a), 32'h1);
    #2;
    rst = 1'b1; req_valid = '0;
    #1;
    chk("t6_busy", 32'(busy_a), 32'h0);
    chk("t6_cor_valid", 32'(cor_valid_a), 32'h0);
    chk("t6_cor_angle", cor_angle_a, 32'h0);
    chk("t6_resp_valid", 32'(resp_valid_a), 32'h0);
    chk("t6_resp_id", 32'(resp_id_a), 32'h0);
    chk("t6_resp_err", 32'(resp_err_a), 32'h0);
    chk("t6_resp_sin", resp_sin_a, 32'h0);
    chk("t6_resp_cos", resp_cos_a, 32'h0);
    chk("t6_req_ready", 32'(req_ready_a), 32'h0);
    tick();
    rst = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t6_grant_after", 32'(req_ready_a), 32'h1);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
